// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      UPDATE = 2'd2,
      REDIR  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch sequencer: reads imem at the current PC, loads IR, drives the PC register
module instr_fetch_unit #(
   parameter logic [31:0] RESET_IR    = cpu_fetch_pkg::NOP_INSTR,
   parameter logic [31:0] INSTR_BYTES = cpu_fetch_pkg::INSTR_BYTES
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_fetch_start,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic [31:0] i_pc_in,
   output logic [31:0] o_pc_next,
   output logic        o_pc_we,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_ir,
   output logic        o_ir_valid,
   output logic        o_busy,
   output logic        o_fault
);
   import cpu_fetch_pkg::*;

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [31:0] r_addr_q;
   logic [31:0] r_ir;
   logic        r_ir_valid;
   logic        r_fault;
   logic [31:0] r_redir_pc_q;
   logic        r_redir_pend;
   logic        r_start_pend;

   logic w_misaligned;
   logic w_start_ok;

   assign w_misaligned = i_fetch_start && (i_pc_in[1:0] != 2'b00);
   assign w_start_ok   = (i_fetch_start || r_start_pend) && !w_misaligned && !r_fault;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_redirect_valid) begin
               w_state_nxt = REDIR;
            end else if (w_start_ok) begin
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (i_imem_ack) begin
               w_state_nxt = UPDATE;
            end
         end
         UPDATE: begin
            w_state_nxt = (r_redir_pend || i_redirect_valid) ? REDIR : IDLE;
         end
         REDIR: begin
            // A redirect landing during REDIR retargets it for one more PC write
            if (i_redirect_valid) begin
               w_state_nxt = REDIR;
            end else if (r_start_pend) begin
               w_state_nxt = REQ;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_pc_we    = 1'b0;
      o_pc_next  = r_addr_q;
      o_imem_req = 1'b0;
      o_busy     = 1'b1;
      case (r_state)
         IDLE:    o_busy = 1'b0;
         REQ:     o_imem_req = 1'b1;
         UPDATE: begin
            o_pc_we   = 1'b1;
            o_pc_next = r_addr_q + INSTR_BYTES;
         end
         REDIR: begin
            o_pc_we   = 1'b1;
            o_pc_next = r_redir_pc_q;
         end
         default: o_busy = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_addr_q     <= 32'd0;
         r_ir         <= RESET_IR;
         r_ir_valid   <= 1'b0;
         r_fault      <= 1'b0;
         r_redir_pc_q <= 32'd0;
         r_redir_pend <= 1'b0;
         r_start_pend <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_redirect_valid) begin
                  r_redir_pc_q <= i_redirect_pc;
                  r_start_pend <= i_fetch_start;
               end else if (w_misaligned) begin
                  r_fault <= 1'b1;
               end else if (w_start_ok) begin
                  r_addr_q     <= i_pc_in;
                  r_ir_valid   <= 1'b0;
                  r_start_pend <= 1'b0;
               end
            end
            REQ, UPDATE: begin
               if (r_state == REQ && i_imem_ack) begin
                  r_ir       <= i_imem_rdata;
                  r_ir_valid <= 1'b1;
               end
               if (i_redirect_valid) begin
                  r_redir_pc_q <= i_redirect_pc;
                  r_redir_pend <= 1'b1;
               end
            end
            REDIR: begin
               r_fault      <= 1'b0;
               r_redir_pend <= 1'b0;
               if (i_redirect_valid) begin
                  r_redir_pc_q <= i_redirect_pc;
               end else if (r_start_pend) begin
                  // PC register only shows the target next cycle, so take it from our copy
                  r_start_pend <= 1'b0;
                  r_addr_q     <= r_redir_pc_q;
                  r_ir_valid   <= 1'b0;
               end
            end
            default: r_redir_pend <= 1'b0;
         endcase
      end
   end

   assign o_imem_addr = r_addr_q;
   assign o_ir        = r_ir;
   assign o_ir_valid  = r_ir_valid;
   assign o_fault     = r_fault;

endmodule
